// File: rtl/murax_io_pkg.sv
// Shared constants and types for the Murax board I/O conditioning logic.
// Defaults are derived from the 27 MHz main clock.
package murax_io_pkg;

  localparam int unsigned CLK_HZ      = 27000000;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned LONG_MS     = 1000;

  function automatic int unsigned ms_to_cycles(
    input int unsigned ms
  );
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES_DEF =
    ms_to_cycles(DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES_DEF =
    ms_to_cycles(LONG_MS);

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic lng;
  } btn_evt_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter,
// saturating hold counter and registered edge/long pulses.
module debounce_channel
  import murax_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit          INVERT          = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     raw_i,
  output btn_evt_t evt_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          long_q, long_d;
  logic          samp;

  assign samp = s2_q ^ INVERT;

  always_comb begin
    s1_d    = raw_i;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (samp == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = samp;
      cnt_d   = '0;
      rise_d  = samp;
      fall_d  = !samp;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Pulse once on the step into saturation; stay quiet until release.
  always_comb begin
    hcnt_d = hcnt_q;
    long_d = 1'b0;
    if (!level_q) begin
      hcnt_d = '0;
    end else if (hcnt_q != HOLD_MAX) begin
      hcnt_d = hcnt_q + HW'(1);
      long_d = (hcnt_d == HOLD_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

  assign evt_o.level = level_q;
  assign evt_o.rise  = rise_q;
  assign evt_o.fall  = fall_q;
  assign evt_o.lng   = long_q;

endmodule

// File: rtl/gpio_debounce.sv
// Push-button conditioner feeding io_gpioA_read: WIDTH independent
// debounce channels in the io_mainClk domain.
module gpio_debounce
  import murax_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit          INVERT          = 1'b0
) (
  input  logic             io_mainClk,
  input  logic             io_asyncResetn,
  input  logic [WIDTH-1:0] io_raw,
  output logic [WIDTH-1:0] io_level,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic [WIDTH-1:0] io_long
);

  btn_evt_t evt [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .INVERT         (INVERT)
    ) u_ch (
      .clk  (io_mainClk),
      .rst_n(io_asyncResetn),
      .raw_i(io_raw[i]),
      .evt_o(evt[i])
    );

    assign io_level[i] = evt[i].level;
    assign io_rise[i]  = evt[i].rise;
    assign io_fall[i]  = evt[i].fall;
    assign io_long[i]  = evt[i].lng;
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge
// monitor pops one per observed pulse and checks channel/kind/cycle.
module tb_gpio_debounce;

  localparam int D = 8;
  localparam int L = 32;

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n;
  logic [1:0] raw0, raw1;
  logic [1:0] lvl0, rise0, fall0, long0;
  logic [1:0] lvl1, rise1, fall1, long1;

  always #5 clk = ~clk;

  gpio_debounce #(
    .WIDTH(2), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .INVERT(1'b0)
  ) dut0 (
    .io_mainClk    (clk),
    .io_asyncResetn(rst0_n),
    .io_raw        (raw0),
    .io_level      (lvl0),
    .io_rise       (rise0),
    .io_fall       (fall0),
    .io_long       (long0)
  );

  gpio_debounce #(
    .WIDTH(2), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .INVERT(1'b1)
  ) dut1 (
    .io_mainClk    (clk),
    .io_asyncResetn(rst1_n),
    .io_raw        (raw1),
    .io_level      (lvl1),
    .io_rise       (rise1),
    .io_fall       (fall1),
    .io_long       (long1)
  );

  typedef struct {
    int  dut;
    int  ch;
    byte kind;
    int  at;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic pulse_of(input int u, input int c,
                                    input int k);
    logic [1:0] v;
    case (k)
      0:       v = (u == 0) ? rise0 : rise1;
      1:       v = (u == 0) ? fall0 : fall1;
      default: v = (u == 0) ? long0 : long1;
    endcase
    return v[c];
  endfunction

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    byte kn;
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_pulse dut%0d ch%0d %c: absent, required at cycle %0d",
               e.dut, e.ch, e.kind, e.at);
    end
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 3; k++) begin
          case (k)
            0:       kn = "R";
            1:       kn = "F";
            default: kn = "L";
          endcase
          if (pulse_of(u, c, k)) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_pulse dut%0d ch%0d %c at cycle %0d, required none",
                       u, c, kn, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.dut != u || e.ch != c || e.kind != kn || e.at != cyc) begin
                failures++;
                $display("FAIL pulse_match got dut%0d ch%0d %c @%0d, required dut%0d ch%0d %c @%0d",
                         u, c, kn, cyc, e.dut, e.ch, e.kind, e.at);
              end
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_ev(input int u, input int c, input byte k,
                           input int at);
    ev_t e;
    e.dut  = u;
    e.ch   = c;
    e.kind = k;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got %0d required %0d", nm, act, req);
    end
  endtask

  int pat[6] = '{1, 0, 1, 1, 0, 1};
  int s, r, f;

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    raw0   = 2'b00;
    raw1   = 2'b11;
    step(3);
    chk("rst_level0", int'(lvl0), 0);
    chk("rst_rise0", int'(rise0), 0);
    chk("rst_fall0", int'(fall0), 0);
    chk("rst_long0", int'(long0), 0);
    chk("rst_level1", int'(lvl1), 0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    step(20);
    chk("inv_idle_level", int'(lvl1), 0);

    // Clean press, long press, release
    raw0[0] = 1'b1;
    s = cyc + 1;
    r = s + 1 + D;
    expect_ev(0, 0, "R", r);
    expect_ev(0, 0, "L", r + L);
    wait_until(r - 1);
    chk("press_level_before", int'(lvl0), 0);
    wait_until(r);
    chk("press_level", int'(lvl0), 1);
    wait_until(r + L + 100);
    chk("long_held_level", int'(lvl0), 1);
    raw0[0] = 1'b0;
    s = cyc + 1;
    f = s + 1 + D;
    expect_ev(0, 0, "F", f);
    wait_until(f);
    chk("release_level", int'(lvl0), 0);
    step(10);

    // Bounce
    foreach (pat[i]) begin
      raw0[0] = pat[i][0];
      if (i == 5) s = cyc + 1;
      step(1);
    end
    r = s + 1 + D;
    expect_ev(0, 0, "R", r);
    wait_until(r - 1);
    chk("bounce_level_before", int'(lvl0), 0);
    wait_until(r);
    chk("bounce_level", int'(lvl0), 1);
    step(2);
    raw0[0] = 1'b0;
    f = cyc + 2 + D;
    expect_ev(0, 0, "F", f);
    wait_until(f);
    step(10);

    // Short press: no long pulse
    raw0[0] = 1'b1;
    r = cyc + 2 + D;
    expect_ev(0, 0, "R", r);
    wait_until(r + 20);
    raw0[0] = 1'b0;
    f = cyc + 2 + D;
    expect_ev(0, 0, "F", f);
    wait_until(f);
    chk("short_level", int'(lvl0), 0);
    step(10);

    // Pin toggling every cycle
    for (int i = 0; i < 40; i++) begin
      raw0[1] = ~raw0[1];
      step(1);
      if (i == 20) chk("toggle_level_mid", int'(lvl0), 0);
    end
    raw0[1] = 1'b0;
    step(12);
    chk("toggle_level", int'(lvl0), 0);

    // Both channels together
    raw0 = 2'b11;
    r = cyc + 2 + D;
    expect_ev(0, 0, "R", r);
    expect_ev(0, 1, "R", r);
    wait_until(r);
    chk("both_level", int'(lvl0), 3);
    step(3);
    raw0 = 2'b00;
    f = cyc + 2 + D;
    expect_ev(0, 0, "F", f);
    expect_ev(0, 1, "F", f);
    wait_until(f);
    chk("both_release", int'(lvl0), 0);
    step(10);

    // Reset while a press is pending
    raw0[0] = 1'b1;
    step(5);
    rst0_n = 1'b0;
    #1;
    chk("midrst_level", int'(lvl0), 0);
    chk("midrst_pulses", int'({rise0, fall0, long0}), 0);
    step(1);
    rst0_n = 1'b1;
    s = cyc + 1;
    r = s + 1 + D;
    expect_ev(0, 0, "R", r);
    wait_until(r - 1);
    chk("midrst_level_before", int'(lvl0), 0);
    wait_until(r);
    chk("midrst_level_after", int'(lvl0), 1);
    raw0[0] = 1'b0;
    f = cyc + 2 + D;
    expect_ev(0, 0, "F", f);
    wait_until(f);
    step(10);

    // Inverted polarity, pin idle high through reset
    rst1_n = 1'b0;
    step(2);
    rst1_n = 1'b1;
    step(50);
    chk("inv_level_idle", int'(lvl1), 0);
    raw1[0] = 1'b0;
    r = cyc + 2 + D;
    expect_ev(1, 0, "R", r);
    wait_until(r);
    chk("inv_press_level", int'(lvl1), 1);
    raw1[0] = 1'b1;
    f = cyc + 2 + D;
    expect_ev(1, 0, "F", f);
    wait_until(f);
    chk("inv_release_level", int'(lvl1), 0);
    step(10);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL leftover dut%0d ch%0d %c: absent, required at cycle %0d",
               e.dut, e.ch, e.kind, e.at);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
